// File: rtl/can_frame_decoder.sv
// Decodes an unstuffed CAN 2.0A standard frame from the receiver snapshot, one bit per clock.
// Optional acceptance filtering on the identifier is enabled by defining CAN_ID_FILTER_EN.
module can_frame_decoder #(
   parameter logic [10:0] ACC_ID   = 11'h000,
   parameter logic [10:0] ACC_MASK = 11'h000
) (
   input  logic          sys_clk,
   input  logic          rst,
   input  logic [128:1]  rx_message,
   input  logic          RXOK,
   output logic [10:0]   rx_id,
   output logic          rx_rtr,
   output logic [3:0]    rx_dlc,
   output logic [63:0]   rx_data,
   output logic          frame_valid,
   output logic          crc_err,
   output logic          form_err,
   output logic          overrun,
   output logic          busy
);

   // state | meaning
   // IDLE  | waiting for an RXOK rising edge
   // HDR   | SOF, ID, RTR, IDE, r0, DLC (19 bits)
   // DATA  | 8*n data bits, written top-down into the data word
   // CRC   | 15 received CRC bits, accumulation stopped
   // TAIL  | CRC delimiter, ACK slot, ACK delimiter, EOF (10 bits)
   // DONE  | result pulses, publish decoded fields
   typedef enum logic [2:0] {IDLE, HDR, DATA, CRC, TAIL, DONE} state_t;

   state_t       state;
   logic [127:0] sr;
   logic [6:0]   cnt;
   logic [5:0]   data_last;
   logic [14:0]  crc_acc;
   logic [14:0]  crc_rx;
   logic         form_bad;
   logic [10:0]  id_w;
   logic         rtr_w;
   logic [3:0]   dlc_w;
   logic [63:0]  data_w;
   logic         rxok_d;

   logic        bit_in;
   logic        rxok_rise;
   logic        crc_nxt;
   logic [14:0] crc_upd;
   logic [3:0]  dlc_new;
   logic [2:0]  n_m1;
   logic        go_data;
   logic        crc_bad;
   logic        frame_ok;
   logic        id_match;

   assign bit_in    = sr[127];
   assign rxok_rise = RXOK & ~rxok_d;
   assign crc_nxt   = bit_in ^ crc_acc[14];
   assign crc_upd   = {crc_acc[13:0], 1'b0} ^ (crc_nxt ? 15'h4599 : 15'h0000);
   assign dlc_new   = {dlc_w[2:0], bit_in};
   // DLC above 8 still means eight bytes on the wire
   assign n_m1      = dlc_new[3] ? 3'd7 : (dlc_new[2:0] - 3'd1);
   assign go_data   = ~rtr_w & (dlc_new != 4'd0);
   assign crc_bad   = (crc_acc != crc_rx);
   assign frame_ok  = ~crc_bad & ~form_bad;
   assign busy      = (state != IDLE);

`ifdef CAN_ID_FILTER_EN
   assign id_match  = (((id_w ^ ACC_ID) & ACC_MASK) == 11'h000);
`else
   assign id_match  = 1'b1;
`endif

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state       <= IDLE;
         sr          <= '0;
         cnt         <= '0;
         data_last   <= '0;
         crc_acc     <= '0;
         crc_rx      <= '0;
         form_bad    <= 1'b0;
         id_w        <= '0;
         rtr_w       <= 1'b0;
         dlc_w       <= '0;
         data_w      <= '0;
         rxok_d      <= 1'b1;
         rx_id       <= '0;
         rx_rtr      <= 1'b0;
         rx_dlc      <= '0;
         rx_data     <= '0;
         frame_valid <= 1'b0;
         crc_err     <= 1'b0;
         form_err    <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         rxok_d      <= RXOK;
         frame_valid <= 1'b0;
         crc_err     <= 1'b0;
         form_err    <= 1'b0;
         overrun     <= 1'b0;
         sr          <= {sr[126:0], 1'b0};

         case (state)
            HDR: begin
               crc_acc <= crc_upd;
               cnt     <= cnt + 7'd1;
               if (cnt == 7'd0 || cnt == 7'd13)
                  form_bad <= form_bad | bit_in;
               else if (cnt >= 7'd1 && cnt <= 7'd11)
                  id_w <= {id_w[9:0], bit_in};
               else if (cnt == 7'd12)
                  rtr_w <= bit_in;
               else if (cnt >= 7'd15)
                  dlc_w <= dlc_new;
               if (cnt == 7'd18) begin
                  cnt       <= '0;
                  data_last <= {n_m1, 3'b111};
                  state     <= go_data ? DATA : CRC;
               end
            end
            DATA: begin
               crc_acc                      <= crc_upd;
               cnt                          <= cnt + 7'd1;
               data_w[6'd63 - cnt[5:0]]     <= bit_in;
               if (cnt[5:0] == data_last) begin
                  cnt   <= '0;
                  state <= CRC;
               end
            end
            CRC: begin
               crc_rx <= {crc_rx[13:0], bit_in};
               cnt    <= cnt + 7'd1;
               if (cnt == 7'd14) begin
                  cnt   <= '0;
                  state <= TAIL;
               end
            end
            TAIL: begin
               cnt <= cnt + 7'd1;
               // bit 1 is the ACK slot, which any value may occupy
               if (cnt != 7'd1)
                  form_bad <= form_bad | ~bit_in;
               if (cnt == 7'd9) begin
                  cnt   <= '0;
                  state <= DONE;
               end
            end
            DONE: begin
               frame_valid <= frame_ok & id_match;
               crc_err     <= crc_bad;
               form_err    <= form_bad;
               if (~frame_ok | id_match) begin
                  rx_id   <= id_w;
                  rx_rtr  <= rtr_w;
                  rx_dlc  <= dlc_w;
                  rx_data <= data_w;
               end
               state <= IDLE;
            end
            default: ;
         endcase

         if (rxok_rise) begin
            if (state == IDLE || state == DONE) begin
               sr       <= rx_message;
               state    <= HDR;
               cnt      <= '0;
               crc_acc  <= '0;
               crc_rx   <= '0;
               form_bad <= 1'b0;
               id_w     <= '0;
               rtr_w    <= 1'b0;
               dlc_w    <= '0;
               data_w   <= '0;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_can_frame_decoder.sv
// Directed bench for can_frame_decoder: frame table plus overrun and reset sequences.
module tb_can_frame_decoder;

   logic          sys_clk = 1'b0;
   logic          rst;
   logic [127:0]  rx_message;
   logic          RXOK;
   logic [10:0]   rx_id;
   logic          rx_rtr;
   logic [3:0]    rx_dlc;
   logic [63:0]   rx_data;
   logic          frame_valid;
   logic          crc_err;
   logic          form_err;
   logic          overrun;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   can_frame_decoder #(.ACC_ID(11'h120), .ACC_MASK(11'h7F0)) dut (
      .sys_clk(sys_clk), .rst(rst), .rx_message(rx_message), .RXOK(RXOK),
      .rx_id(rx_id), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc), .rx_data(rx_data),
      .frame_valid(frame_valid), .crc_err(crc_err), .form_err(form_err),
      .overrun(overrun), .busy(busy)
   );

   // form_sel: 0 clean, 1 EOF bit 3 low, 2 SOF high, 3 IDE high, 4 ACK slot high, 5 CRC delimiter low
   typedef struct {
      logic [10:0] id;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
      logic [14:0] crc_x;
      int          form_sel;
      int          lat;
      logic        exp_valid;
      logic        exp_crc;
      logic        exp_form;
      logic [63:0] exp_data;
      logic        rej;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
      logic nxt;
      nxt = b ^ c[14];
      return {c[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
   endfunction

   function automatic logic [127:0] build_frame(input logic [10:0] id, input logic rtr,
         input logic [3:0] dlc, input logic [63:0] data, input logic [14:0] crc_x, input int form_sel);
      logic [127:0] f;
      logic [18:0]  hdr;
      logic [14:0]  c;
      logic [9:0]   tail;
      int           p;
      int           nbits;
      f = '0;
      p = 127;
      c = '0;
      hdr = {(form_sel == 2), id, rtr, (form_sel == 3), 1'b0, dlc};
      for (int i = 18; i >= 0; i--) begin
         f[p] = hdr[i];
         c = crc_step(c, hdr[i]);
         p--;
      end
      nbits = rtr ? 0 : ((dlc > 4'd8) ? 64 : int'(dlc) * 8);
      for (int i = 0; i < nbits; i++) begin
         f[p] = data[63 - i];
         c = crc_step(c, data[63 - i]);
         p--;
      end
      c = c ^ crc_x;
      for (int i = 14; i >= 0; i--) begin
         f[p] = c[i];
         p--;
      end
      tail = {(form_sel != 5), (form_sel == 4), 1'b1, 7'h7F};
      if (form_sel == 1) tail[4] = 1'b0;
      for (int i = 9; i >= 0; i--) begin
         f[p] = tail[i];
         p--;
      end
      return f;
   endfunction

   // Leaves the bench 1 time unit after E0, the edge that accepts the frame.
   task automatic start_frame(input logic [127:0] f);
      RXOK = 1'b0;
      @(posedge sys_clk); #1;
      rx_message = f;
      RXOK = 1'b1;
      @(posedge sys_clk); #1;
   endtask

   initial begin
      logic [10:0] p_id;
      logic        p_rtr;
      logic [3:0]  p_dlc;
      logic [63:0] p_data;
      logic        eff_rej;
      int          spurious;
      int          pulses;
      int          busy_hi;

      vecs[0] = '{11'h123, 1'b0, 4'h2, 64'hA55A_0000_0000_0000, 15'h0000, 0, 61, 1'b1, 1'b0, 1'b0, 64'hA55A_0000_0000_0000, 1'b0};
      vecs[1] = '{11'h123, 1'b0, 4'h2, 64'hA55A_0000_0000_0000, 15'h0001, 0, 61, 1'b0, 1'b1, 1'b0, 64'hA55A_0000_0000_0000, 1'b0};
      vecs[2] = '{11'h123, 1'b0, 4'h2, 64'hA55A_0000_0000_0000, 15'h0000, 1, 61, 1'b0, 1'b0, 1'b1, 64'hA55A_0000_0000_0000, 1'b0};
      vecs[3] = '{11'h7FF, 1'b1, 4'h4, 64'hDEAD_BEEF_0000_0000, 15'h0000, 0, 45, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 1'b1};
      vecs[4] = '{11'h12A, 1'b0, 4'hF, 64'h0102_0304_0506_0708, 15'h0000, 0, 109, 1'b1, 1'b0, 1'b0, 64'h0102_0304_0506_0708, 1'b0};
      vecs[5] = '{11'h13A, 1'b0, 4'h1, 64'h9977_6655_4433_2211, 15'h0000, 0, 53, 1'b1, 1'b0, 1'b0, 64'h9900_0000_0000_0000, 1'b1};
      vecs[6] = '{11'h000, 1'b0, 4'h0, 64'h0000_0000_0000_0000, 15'h0000, 2, 45, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0000, 1'b0};
      vecs[7] = '{11'h555, 1'b0, 4'h8, 64'h1122_3344_5566_7788, 15'h0000, 3, 109, 1'b0, 1'b0, 1'b1, 64'h1122_3344_5566_7788, 1'b0};
      vecs[8] = '{11'h120, 1'b0, 4'h3, 64'hABCD_EF11_2233_4455, 15'h0000, 4, 69, 1'b1, 1'b0, 1'b0, 64'hABCD_EF00_0000_0000, 1'b0};
      vecs[9] = '{11'h123, 1'b0, 4'h2, 64'hA55A_0000_0000_0000, 15'h4000, 5, 61, 1'b0, 1'b1, 1'b1, 64'hA55A_0000_0000_0000, 1'b0};

      // Reset with RXOK already high: nothing may start after release.
      rst = 1'b1;
      RXOK = 1'b1;
      rx_message = build_frame(11'h123, 1'b0, 4'h2, 64'hA55A_0000_0000_0000, 15'h0000, 0);
      repeat (3) @(posedge sys_clk);
      #1;
      check("reset_rx_id", 64'(rx_id), 64'h0);
      check("reset_rx_data", rx_data, 64'h0);
      check("reset_pulses", 64'({frame_valid, crc_err, form_err, overrun}), 64'h0);
      check("reset_busy", 64'(busy), 64'h0);
      rst = 1'b0;
      busy_hi = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge sys_clk); #1;
         if (busy) busy_hi++;
      end
      check("rxok_high_at_release_no_start", 64'(busy_hi), 64'h0);

      p_id = '0; p_rtr = 1'b0; p_dlc = '0; p_data = '0;
      for (int v = 0; v < 10; v++) begin
`ifdef CAN_ID_FILTER_EN
         eff_rej = vecs[v].rej & vecs[v].exp_valid;
`else
         eff_rej = 1'b0;
`endif
         start_frame(build_frame(vecs[v].id, vecs[v].rtr, vecs[v].dlc, vecs[v].data,
                                 vecs[v].crc_x, vecs[v].form_sel));
         spurious = 0;
         for (int k = 1; k <= vecs[v].lat; k++) begin
            @(posedge sys_clk); #1;
            if (k == 1) check($sformatf("v%0d_busy", v), 64'(busy), 64'h1);
            if (k < vecs[v].lat && (frame_valid | crc_err | form_err | overrun)) spurious++;
         end
         check($sformatf("v%0d_early_pulse", v), 64'(spurious), 64'h0);
         check($sformatf("v%0d_frame_valid", v), 64'(frame_valid), 64'(vecs[v].exp_valid & ~eff_rej));
         check($sformatf("v%0d_crc_err", v), 64'(crc_err), 64'(vecs[v].exp_crc));
         check($sformatf("v%0d_form_err", v), 64'(form_err), 64'(vecs[v].exp_form));
         if (!eff_rej) begin
            p_id = vecs[v].id; p_rtr = vecs[v].rtr; p_dlc = vecs[v].dlc; p_data = vecs[v].exp_data;
         end
         check($sformatf("v%0d_rx_id", v), 64'(rx_id), 64'(p_id));
         check($sformatf("v%0d_rx_rtr", v), 64'(rx_rtr), 64'(p_rtr));
         check($sformatf("v%0d_rx_dlc", v), 64'(rx_dlc), 64'(p_dlc));
         check($sformatf("v%0d_rx_data", v), rx_data, p_data);
         @(posedge sys_clk); #1;
         check($sformatf("v%0d_pulse_width", v), 64'({frame_valid, crc_err, form_err}), 64'h0);
         check($sformatf("v%0d_idle", v), 64'(busy), 64'h0);
      end

      // Second RXOK edge during an 8-byte frame: overrun, first frame unaffected.
      start_frame(build_frame(11'h125, 1'b0, 4'h8, 64'hCAFE_F00D_1234_5678, 15'h0000, 0));
      pulses = 0;
      for (int k = 1; k <= 130; k++) begin
         @(posedge sys_clk); #1;
         if (k == 5) RXOK = 1'b0;
         if (k == 20) begin
            check("ovr_before", 64'(overrun), 64'h0);
            RXOK = 1'b1;
         end
         if (k == 21) check("ovr_pulse", 64'(overrun), 64'h1);
         if (k == 22) check("ovr_width", 64'(overrun), 64'h0);
         if (k == 109) begin
            check("ovr_frame_valid", 64'(frame_valid), 64'h1);
            check("ovr_rx_id", 64'(rx_id), 64'h125);
            check("ovr_rx_data", rx_data, 64'hCAFE_F00D_1234_5678);
         end
         if (frame_valid) pulses++;
      end
      check("ovr_single_valid", 64'(pulses), 64'h1);
      check("ovr_idle_after", 64'(busy), 64'h0);

      // Reset in the middle of a decode aborts with no pulses; RXOK stays high through it.
      start_frame(build_frame(11'h126, 1'b0, 4'h8, 64'h0011_2233_4455_6677, 15'h0000, 0));
      pulses = 0;
      busy_hi = 0;
      for (int k = 1; k <= 150; k++) begin
         @(posedge sys_clk); #1;
         if (k == 29) rst = 1'b1;
         if (k == 30) begin
            check("rst_mid_busy", 64'(busy), 64'h0);
            check("rst_mid_rx_id", 64'(rx_id), 64'h0);
            check("rst_mid_rx_data", rx_data, 64'h0);
            check("rst_mid_rx_dlc", 64'({rx_rtr, rx_dlc}), 64'h0);
         end
         if (k == 32) rst = 1'b0;
         if (k >= 30) begin
            if (frame_valid | crc_err | form_err | overrun) pulses++;
            if (busy) busy_hi++;
         end
      end
      check("rst_mid_no_pulse", 64'(pulses), 64'h0);
      check("rst_mid_no_restart", 64'(busy_hi), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/can_frame_decoder.md
Name: can_frame_decoder

Overview:
- Sits directly downstream of the 128-bit serial receiver; consumes its parallel snapshot `rx_message[128:1]` and its `RXOK` strobe.
- Walks the captured bits one per clock and extracts the CAN 2.0A standard-frame fields: ID, RTR, DLC and data.
- Recomputes CRC-15 and checks the fixed-form bits, then presents decoded fields with a one-cycle valid or error pulse to the controller/host side.
- No bit-destuffing; the frame arrives unstuffed.

Parameters:
- ACC_ID, 11'h000, acceptance ID. Used only with CAN_ID_FILTER_EN.
- ACC_MASK, 11'h000, acceptance mask; 1 = compare this ID bit. Used only with CAN_ID_FILTER_EN.

Ports:
- sys_clk  in  1  system clock; all logic on posedge. The receiver updates on negedge, so inputs are stable here.
- rst  in  1  synchronous, active-high reset.
- rx_message  in  128  captured frame; bit 128 = first bit on the bus (SOF).
- RXOK  in  1  receiver done strobe; its rising edge marks a new frame.
- rx_id  out  11  decoded identifier.
- rx_rtr  out  1  RTR bit.
- rx_dlc  out  4  raw DLC as received.
- rx_data  out  64  data bytes; byte0 in [63:56]; unused bytes 0.
- frame_valid  out  1  1-cycle pulse: frame good (and accepted, if filter enabled).
- crc_err  out  1  1-cycle pulse: CRC mismatch.
- form_err  out  1  1-cycle pulse: a fixed-form bit is wrong.
- overrun  out  1  1-cycle pulse: new frame dropped because the block was busy.
- busy  out  1  high while not IDLE.

Behaviour:
- Reset: every output 0, FSM to IDLE, shift register/CRC/counters 0.
- RXOK edge-detect register resets to 1, so an RXOK already high at reset release never starts a frame.
- Reset mid-decode aborts with no pulses.
- Frame layout, MSB first:
  - SOF (1), ID (11), RTR (1), IDE (1), r0 (1), DLC (4).
  - DATA: 8·n bits, where n = 0 if RTR=1, otherwise min(DLC, 8).
  - CRC (15).
  - Tail: CRC delimiter (1), ACK slot (1), ACK delimiter (1), EOF (7).
  - Remaining low-order bits are ignored.
- FSM states: IDLE, HDR, DATA, CRC, TAIL, DONE.
  - IDLE/DONE + RXOK rising edge (edge E0): load rx_message into a 128-bit shift register, clear CRC, go to HDR with counter 0.
  - HDR: consume 19 bits. Capture ID/RTR/DLC. Then go to DATA if n>0, else CRC.
  - DATA: consume 8·n bits into rx_data from the top down, then go to CRC.
  - CRC: consume 15 bits into a received-CRC register; CRC accumulation stops here. Then go to TAIL.
  - TAIL: consume 10 bits, then go to DONE.
  - DONE: drive the result pulses for one cycle, then go to IDLE unless a new edge is accepted.
- One bit is consumed per posedge, so frame_valid/crc_err/form_err are registered at edge E0 + 45 + 8·n.
- CRC-15 (poly 0x4599, init 0), accumulated over SOF..last data bit:
  - nxt = bit ^ crc[14]
  - crc = {crc[13:0], 0} ^ (nxt ? 15'h4599 : 0)
- crc_err = computed CRC != received CRC.
- form_err = SOF≠0, IDE≠0, CRC delimiter≠1, ACK delimiter≠1, or any EOF bit≠1. The ACK slot value is not checked.
- frame_valid = !crc_err && !form_err. crc_err and form_err may pulse together; frame_valid never coincides with either.
- rx_id/rx_rtr/rx_dlc/rx_data update at DONE for every frame, including errored ones, and hold until the next DONE.
- DLC 9–15: rx_dlc reports the raw value; 8 data bytes are consumed.
- RXOK rising edge in HDR/DATA/CRC/TAIL: overrun pulses the next cycle, the new frame is discarded, and the current decode continues unaffected.
- RXOK level held high causes no retrigger.

Optional Feature:
- Macro: CAN_ID_FILTER_EN.
- Defined:
  - At DONE, a frame with no errors and ((rx_id ^ ACC_ID) & ACC_MASK) != 0 is rejected: frame_valid stays 0 and rx_* keep their previous values.
  - Errored frames still pulse crc_err/form_err.
- Undefined: no filter logic; ACC_ID/ACC_MASK are unused; every error-free frame pulses frame_valid.

Test Plan:
- Data frame: ID=11'h123, RTR=0, DLC=2, data A5,5A, correct CRC from the reference model, good tail -> frame_valid at E0+61; rx_id=123, rx_dlc=2, rx_data=64'hA55A_0000_0000_0000; crc_err=form_err=0.
- Same frame with CRC LSB flipped -> crc_err=1 at E0+61, frame_valid=0, rx_id=123 still updated. Separately, EOF bit 3 = 0 -> form_err=1 only.
- RTR frame: ID=11'h7FF, RTR=1, DLC=4 -> no data consumed; pulse at E0+45; rx_data=0, rx_dlc=4.
- DLC=4'hF with 8 bytes 01..08 -> pulse at E0+109; rx_dlc=F, rx_data=64'h0102030405060708.
- Second RXOK edge at E0+20 of an 8-byte frame -> overrun at E0+21; first frame completes normally; exactly one frame_valid. Rst at E0+30 -> all outputs 0, no pulse. RXOK high through reset -> nothing starts.
- With CAN_ID_FILTER_EN, ACC_ID=11'h120, ACC_MASK=11'h7F0: ID 11'h12A accepted (frame_valid=1); ID 11'h13A rejected (frame_valid=0, rx_id unchanged).
